// File: rtl/dca_mask_scan_scheduler.sv
// Mask-driven multi-tap command scheduler: walks set rows of row_mask and,
// per row, every (position, tap) pair, issuing a valid/ready command for each
// candidate whose source column p-t is set in col_mask.
// Ports: clk/rstnn, enable/start/abort control, row_mask/col_mask, busy,
//   cmd_valid/cmd_ready with cmd_row/pos/src/tap/row_first, row_end,
//   done/aborted.
module dca_mask_scan_scheduler #(
   parameter int ROW_WIDTH       = 8,
   parameter int COL_WIDTH       = 8,
   parameter int NUM_TAP         = 2,
   parameter int ROW_INDEX_WIDTH = 3,
   parameter int POS_INDEX_WIDTH = 4,
   parameter int TAP_INDEX_WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rstnn,
   input  logic                       enable,
   input  logic                       start,
   input  logic                       abort,
   input  logic [ROW_WIDTH-1:0]       row_mask,
   input  logic [COL_WIDTH-1:0]       col_mask,
   output logic                       busy,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [ROW_INDEX_WIDTH-1:0] cmd_row,
   output logic [POS_INDEX_WIDTH-1:0] cmd_pos,
   output logic [POS_INDEX_WIDTH-1:0] cmd_src,
   output logic [TAP_INDEX_WIDTH-1:0] cmd_tap,
   output logic                       cmd_row_first,
   output logic                       row_end,
   output logic                       done,
   output logic                       aborted
);

   localparam int POS_NUM = COL_WIDTH + NUM_TAP - 1;
   localparam int RIW = ROW_INDEX_WIDTH;
   localparam int PIW = POS_INDEX_WIDTH;
   localparam int TIW = TAP_INDEX_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FINISH
   } state_t;

   state_t state, state_d;

   logic [ROW_WIDTH-1:0] rows;
   logic [COL_WIDTH-1:0] cols;
   logic [RIW-1:0] r, r_d;
   logic [PIW-1:0] p, p_d;
   logic [TIW-1:0] t, t_d;
   logic first, first_d;
   logic ab, ab_d;

   logic accept;
   logic [PIW-1:0] src;
   logic row_set;
   logic in_range;
   logic qual;
   logic adv;
   logic last_t;
   logic last_cand;
   logic last_row;

   assign accept = (state == IDLE) && start && enable;

   // Shift-and-mask selects keep index widths independent of mask widths.
   assign row_set = |(rows & (ROW_WIDTH'(1) << r));
   assign src = p - PIW'(t);
   // The extra bit lets COL_WIDTH be compared even when it does not fit PIW.
   assign in_range = (p >= PIW'(t))
                  && ({1'b0, src} < (PIW + 1)'(COL_WIDTH));
   assign qual = (state == SCAN) && row_set && in_range
              && |(cols & (COL_WIDTH'(1) << src));

   // Issuing candidates wait only for the handshake; others need enable.
   assign adv = qual ? cmd_ready : enable;
   assign last_t = (t == TIW'(NUM_TAP - 1));
   assign last_cand = (p == PIW'(POS_NUM - 1)) && last_t;
   assign last_row = (r == RIW'(ROW_WIDTH - 1));

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state <= IDLE;
         rows  <= '0;
         cols  <= '0;
         r     <= '0;
         p     <= '0;
         t     <= '0;
         first <= 1'b0;
         ab    <= 1'b0;
      end else begin
         state <= state_d;
         r     <= r_d;
         p     <= p_d;
         t     <= t_d;
         first <= first_d;
         ab    <= ab_d;
         if (accept) begin
            rows <= row_mask;
            cols <= col_mask;
         end
      end
   end

   always_comb begin
      state_d = state;
      r_d     = r;
      p_d     = p;
      t_d     = t;
      first_d = first;
      ab_d    = ab;
      row_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               r_d     = '0;
               p_d     = '0;
               t_d     = '0;
               first_d = 1'b1;
               ab_d    = 1'b0;
               if ((row_mask == '0) || (col_mask == '0)) begin
                  state_d = FINISH;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (abort) begin
               // A same-cycle handshake has already transferred downstream.
               state_d = FINISH;
               ab_d    = 1'b1;
               first_d = 1'b0;
               r_d     = '0;
               p_d     = '0;
               t_d     = '0;
            end else if (adv) begin
               if (qual) begin
                  first_d = 1'b0;
               end
               if (!row_set || last_cand) begin
                  row_end = row_set;
                  p_d     = '0;
                  t_d     = '0;
                  if (last_row) begin
                     state_d = FINISH;
                     r_d     = '0;
                     first_d = 1'b0;
                  end else begin
                     r_d     = r + RIW'(1);
                     first_d = 1'b1;
                  end
               end else if (last_t) begin
                  t_d = '0;
                  p_d = p + PIW'(1);
               end else begin
                  t_d = t + TIW'(1);
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            ab_d    = 1'b0;
            first_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy          = (state != IDLE);
   assign done          = (state == FINISH);
   assign aborted       = done && ab;
   assign cmd_valid     = qual;
   assign cmd_row       = qual ? r : '0;
   assign cmd_pos       = qual ? p : '0;
   assign cmd_src       = qual ? src : '0;
   assign cmd_tap       = qual ? t : '0;
   assign cmd_row_first = qual && first;

endmodule

// File: tb/tb_dca_mask_scan_scheduler.sv
// Directed bench for dca_mask_scan_scheduler (ROW=4, COL=4, TAP=2).
// Expected command lists and cycle numbers are hand-derived constants.
module tb_dca_mask_scan_scheduler;

   logic clk = 1'b0;
   logic rstnn;
   logic enable;
   logic start;
   logic abort;
   logic [3:0] row_mask;
   logic [3:0] col_mask;
   logic busy;
   logic cmd_valid;
   logic cmd_ready;
   logic [1:0] cmd_row;
   logic [2:0] cmd_pos;
   logic [2:0] cmd_src;
   logic [0:0] cmd_tap;
   logic cmd_row_first;
   logic row_end;
   logic done;
   logic aborted;

   dca_mask_scan_scheduler #(
      .ROW_WIDTH(4),
      .COL_WIDTH(4),
      .NUM_TAP(2),
      .ROW_INDEX_WIDTH(2),
      .POS_INDEX_WIDTH(3),
      .TAP_INDEX_WIDTH(1)
   ) dut (
      .clk(clk),
      .rstnn(rstnn),
      .enable(enable),
      .start(start),
      .abort(abort),
      .row_mask(row_mask),
      .col_mask(col_mask),
      .busy(busy),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_row(cmd_row),
      .cmd_pos(cmd_pos),
      .cmd_src(cmd_src),
      .cmd_tap(cmd_tap),
      .cmd_row_first(cmd_row_first),
      .row_end(row_end),
      .done(done),
      .aborted(aborted)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int f, input int r,
                                      input int p, input int s,
                                      input int t);
      return {22'd0, f[0], r[1:0], p[2:0], s[2:0], t[0]};
   endfunction

   logic [31:0] keys[$];
   int cycs[$];
   int re_cnt, re_last, done_cyc, done_ab, done_valid;
   int busy_c1, busy_after, valid_cyc, stable;

   task automatic run_scan(input logic [3:0] rm, input logic [3:0] cm,
                           input int stall, input int abort_at);
      int t0;
      int cyc;
      int left;
      int n;
      bit got_done;
      logic [31:0] k;
      logic [31:0] k0;
      keys.delete();
      cycs.delete();
      re_cnt = 0;
      re_last = -1;
      done_cyc = -1;
      done_ab = -1;
      done_valid = -1;
      busy_c1 = -1;
      valid_cyc = 0;
      stable = 1;
      got_done = 0;
      left = stall;
      n = 0;
      k0 = '0;
      @(negedge clk);
      row_mask = rm;
      col_mask = cm;
      start = 1'b1;
      cmd_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = ecnt;
      for (int i = 0; i < 200 && !got_done; i++) begin
         @(negedge clk);
         cyc = ecnt - t0 + 1;
         abort = 1'b0;
         if (cmd_valid) begin
            valid_cyc++;
            k = {22'd0, cmd_row_first, cmd_row, cmd_pos, cmd_src, cmd_tap};
            if (left > 0) begin
               if (left == stall) k0 = k;
               else if (k != k0) stable = 0;
               cmd_ready = 1'b0;
               left--;
            end else begin
               cmd_ready = 1'b1;
               n++;
               if (n == abort_at) abort = 1'b1;
               keys.push_back(k);
               cycs.push_back(cyc);
            end
         end else begin
            cmd_ready = 1'b1;
         end
         #1;
         if (cyc == 1) busy_c1 = int'(busy);
         if (row_end) begin
            re_cnt++;
            re_last = cyc;
         end
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
            done_ab = int'(aborted);
            done_valid = int'(cmd_valid);
         end
      end
      if (!got_done) check("done_timeout", 0, 1);
      @(negedge clk);
      abort = 1'b0;
      busy_after = int'(busy);
   endtask

   task automatic check_eight(input string tag);
      int ep[4] = '{0, 1, 3, 4};
      int es[4] = '{0, 0, 3, 3};
      int et[4] = '{0, 1, 0, 1};
      int rr;
      check({tag, "_count"}, keys.size(), 8);
      if (keys.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            rr = (i < 4) ? 1 : 3;
            check($sformatf("%s_cmd%0d", tag, i), keys[i],
                  mk((i % 4) == 0, rr, ep[i % 4], es[i % 4], et[i % 4]));
         end
      end
      check({tag, "_row_end"}, re_cnt, 2);
      check({tag, "_done_cyc"}, done_cyc, 23);
      check({tag, "_aborted"}, done_ab, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dcnt;
      rstnn = 1'b0;
      enable = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cmd_ready = 1'b1;
      row_mask = '0;
      col_mask = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, cmd_valid, cmd_row, cmd_pos, cmd_src, cmd_tap,
             cmd_row_first, row_end, done, aborted}, 0);
      rstnn = 1'b1;
      @(negedge clk);

      // start without enable is not accepted
      enable = 1'b0;
      row_mask = 4'b0001;
      col_mask = 4'b0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("enable_gate_busy", busy, 0);
      enable = 1'b1;

      // basic single row / single column
      run_scan(4'b0001, 4'b0001, 0, 0);
      check("t1_count", keys.size(), 2);
      if (keys.size() == 2) begin
         check("t1_cmd0", keys[0], mk(1, 0, 0, 0, 0));
         check("t1_cmd0_cyc", cycs[0], 1);
         check("t1_cmd1", keys[1], mk(0, 0, 1, 0, 1));
      end
      check("t1_row_end_cnt", re_cnt, 1);
      check("t1_row_end_cyc", re_last, 10);
      check("t1_done_cyc", done_cyc, 14);
      check("t1_aborted", done_ab, 0);
      check("t1_busy_c1", busy_c1, 1);
      check("t1_busy_after", busy_after, 0);

      // five-cycle stall on the first command
      run_scan(4'b0001, 4'b0001, 5, 0);
      check("t2_stable", stable, 1);
      check("t2_count", keys.size(), 2);
      if (keys.size() == 2) begin
         check("t2_cmd0", keys[0], mk(1, 0, 0, 0, 0));
         check("t2_cmd0_cyc", cycs[0], 6);
      end
      check("t2_done_cyc", done_cyc, 19);

      // two rows, two source columns
      run_scan(4'b1010, 4'b1001, 0, 0);
      check_eight("t3");

      // empty column mask finishes immediately
      run_scan(4'b1111, 4'b0000, 0, 0);
      check("t4_valid_cycles", valid_cyc, 0);
      check("t4_done_cyc", done_cyc, 1);
      check("t4_busy_c1", busy_c1, 1);
      check("t4_busy_after", busy_after, 0);

      // abort coincident with the second handshake
      run_scan(4'b1010, 4'b1001, 0, 2);
      check("t5_count", keys.size(), 2);
      if (keys.size() == 2) begin
         check("t5_cmd1", keys[1], mk(0, 1, 1, 0, 1));
      end
      check("t5_done_cyc", done_cyc, 6);
      check("t5_aborted", done_ab, 1);
      check("t5_valid_at_done", done_valid, 0);
      check("t5_busy_after", busy_after, 0);
      run_scan(4'b1010, 4'b1001, 0, 0);
      check_eight("t5b");

      // asynchronous reset mid-scan while a command is pending
      @(negedge clk);
      row_mask = 4'b0001;
      col_mask = 4'b0001;
      cmd_ready = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("t6_pre_valid", cmd_valid, 1);
      #2 rstnn = 1'b0;
      #1;
      check("t6_reset_outputs",
            {busy, cmd_valid, cmd_row, cmd_pos, cmd_src, cmd_tap,
             cmd_row_first, row_end, done, aborted}, 0);
      @(negedge clk);
      rstnn = 1'b1;
      cmd_ready = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy || cmd_valid) dcnt++;
      end
      check("t6_no_done_after", dcnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
